// File: rtl/transmission8_scan_ctrl.sv
// ---------------------------------------------------------------------------
// transmission8_scan_ctrl
//
// Scan controller for the 8-channel transmission stage. A start request
// captures an 8-bit word and holds it on oData. The 3-bit channel select
// {oA,oB,oC} then steps 000..111, and each value is held for DWELL clocks.
// oBusy is high while a frame is running. oDone pulses for one cycle at the
// end of each completed frame.
//
// Parameters
//   DWELL       clocks each select value is held (1..255)
//   CONTINUOUS  0: one frame per start
//               1: wrap 111->000, recapture iData and keep scanning until abort
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   iData   in   [7:0] word to transmit, sampled only at frame start or wrap
//   iStart  in   start request (pulse or level)
//   iAbort  in   abort the current scan; wins over iStart and frame end
//   oData   out  [7:0] captured word
//   oA      out  select MSB
//   oB      out  select middle bit
//   oC      out  select LSB
//   oBusy   out  high while scanning
//   oDone   out  one-cycle end-of-frame pulse
//
// All outputs come straight from flops.
//
// State table
//   state | meaning
//   IDLE  | waiting for iStart, select parked at 000
//   SCAN  | stepping select, dwell counter running
//   DONE  | single end-of-frame cycle; a start here is accepted as in IDLE
// ---------------------------------------------------------------------------
module transmission8_scan_ctrl #(
   parameter int unsigned DWELL      = 4,
   parameter bit          CONTINUOUS = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] iData,
   input  logic       iStart,
   input  logic       iAbort,
   output logic [7:0] oData,
   output logic       oA,
   output logic       oB,
   output logic       oC,
   output logic       oBusy,
   output logic       oDone
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scanState_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
   localparam logic [2:0] SEL_LAST   = 3'd7;

   scanState_t state, nextState;
   logic [7:0] dataReg, nextData;
   logic [2:0] selReg, nextSel;
   logic [7:0] dwellCnt, nextDwell;
   logic       busyReg, nextBusy;
   logic       doneReg, nextDone;

   logic startOk;
   logic dwellEnd;

   // A start is only honoured when no abort is present in the same cycle.
   assign startOk  = iStart && !iAbort;
   assign dwellEnd = (dwellCnt == DWELL_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dataReg  <= 8'h00;
         selReg   <= 3'b000;
         dwellCnt <= 8'd0;
         busyReg  <= 1'b0;
         doneReg  <= 1'b0;
      end else begin
         state    <= nextState;
         dataReg  <= nextData;
         selReg   <= nextSel;
         dwellCnt <= nextDwell;
         busyReg  <= nextBusy;
         doneReg  <= nextDone;
      end
   end

   always_comb begin
      nextState = state;
      nextData  = dataReg;
      nextSel   = selReg;
      nextDwell = dwellCnt;
      nextBusy  = busyReg;
      nextDone  = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (startOk) begin
               nextState = SCAN;
               nextData  = iData;
               nextSel   = 3'b000;
               nextDwell = 8'd0;
               nextBusy  = 1'b1;
            end else begin
               nextState = IDLE;
               nextSel   = 3'b000;
               nextDwell = 8'd0;
               nextBusy  = 1'b0;
            end
         end

         SCAN: begin
            if (iAbort) begin
               // Abort drops straight to IDLE, suppressing any oDone and
               // leaving the captured word in place.
               nextState = IDLE;
               nextSel   = 3'b000;
               nextDwell = 8'd0;
               nextBusy  = 1'b0;
            end else if (dwellEnd) begin
               nextDwell = 8'd0;
               if (selReg == SEL_LAST) begin
                  nextSel  = 3'b000;
                  nextDone = 1'b1;
                  if (CONTINUOUS) begin
                     nextData = iData;
                     nextBusy = 1'b1;
                  end else begin
                     nextState = DONE;
                     nextBusy  = 1'b0;
                  end
               end else begin
                  nextSel = selReg + 3'd1;
               end
            end else begin
               nextDwell = dwellCnt + 8'd1;
            end
         end

         default: begin
            nextState = IDLE;
            nextSel   = 3'b000;
            nextDwell = 8'd0;
            nextBusy  = 1'b0;
         end
      endcase
   end

   assign oData        = dataReg;
   assign {oA, oB, oC} = selReg;
   assign oBusy        = busyReg;
   assign oDone        = doneReg;

endmodule

// File: tb/tb_transmission8_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_transmission8_scan_ctrl
//
// Testbench for the scan controller. It drives two instances from one shared
// stimulus stream:
//   unitA  DWELL=4, single-frame mode
//   unitB  DWELL=1, continuous mode
//
// A frame-level reference model keeps track of how many cycles have elapsed
// since the frame was captured. The select value is elapsed/DWELL, and the
// frame ends when elapsed reaches 8*DWELL. After every clock edge the model
// pushes the expected output word into a queue. A monitor pops that word one
// time unit after the edge and compares it with the outputs the DUT presents.
// ---------------------------------------------------------------------------
module tb_transmission8_scan_ctrl;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] sel;
      logic       busy;
      logic       done;
   } outVec_t;

   typedef struct packed {
      logic        active;
      int unsigned elapsed;
      logic [7:0]  data;
   } modelState_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] iData = 8'h00;
   logic       iStart = 1'b0;
   logic       iAbort = 1'b0;

   logic [7:0] aData, bData;
   logic       aA, aB, aC, aBusy, aDone;
   logic       bA, bB, bC, bBusy, bDone;

   int checkCount = 0;
   int passCount  = 0;
   int cycleNum   = 0;

   outVec_t     qA[$];
   outVec_t     qB[$];
   modelState_t stA = '0;
   modelState_t stB = '0;

   always #5 clk = ~clk;

   transmission8_scan_ctrl #(.DWELL(4), .CONTINUOUS(1'b0)) unitA (
      .clk(clk), .rst(rst), .iData(iData), .iStart(iStart), .iAbort(iAbort),
      .oData(aData), .oA(aA), .oB(aB), .oC(aC), .oBusy(aBusy), .oDone(aDone)
   );

   transmission8_scan_ctrl #(.DWELL(1), .CONTINUOUS(1'b1)) unitB (
      .clk(clk), .rst(rst), .iData(iData), .iStart(iStart), .iAbort(iAbort),
      .oData(bData), .oA(bA), .oB(bB), .oC(bC), .oBusy(bBusy), .oDone(bDone)
   );

   // Frame-level reference: computes the outputs expected after one clock edge
   // from the inputs sampled at that edge.
   task automatic modelStep(input modelState_t sIn, input int unsigned dwell,
                            input bit cont, input logic r, input logic st,
                            input logic ab, input logic [7:0] d,
                            output modelState_t sOut, output outVec_t o);
      sOut = sIn;
      o    = '0;
      if (r) begin
         sOut = '0;
      end else if (sIn.active) begin
         if (ab) begin
            sOut.active = 1'b0;
         end else begin
            sOut.elapsed = sIn.elapsed + 1;
            if (sOut.elapsed == 8 * dwell) begin
               o.done       = 1'b1;
               sOut.elapsed = 0;
               if (cont) begin
                  sOut.data = d;
                  o.busy    = 1'b1;
               end else begin
                  sOut.active = 1'b0;
               end
            end else begin
               o.sel  = 3'(sOut.elapsed / dwell);
               o.busy = 1'b1;
            end
         end
      end else if (st && !ab) begin
         sOut.active  = 1'b1;
         sOut.elapsed = 0;
         sOut.data    = d;
         o.busy       = 1'b1;
      end
      o.data = sOut.data;
   endtask

   always @(posedge clk) begin
      modelState_t nA, nB;
      outVec_t     eA, eB;
      modelStep(stA, 4, 1'b0, rst, iStart, iAbort, iData, nA, eA);
      modelStep(stB, 1, 1'b1, rst, iStart, iAbort, iData, nB, eB);
      stA = nA;
      stB = nB;
      qA.push_back(eA);
      qB.push_back(eB);
      cycleNum++;
   end

   task automatic compareOut(input string name, input outVec_t exp, input outVec_t act);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("FAIL %s cycle %0d: got data=%h sel=%b busy=%b done=%b, expected data=%h sel=%b busy=%b done=%b",
                  name, cycleNum, act.data, act.sel, act.busy, act.done,
                  exp.data, exp.sel, exp.busy, exp.done);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (qA.size() > 0)
         compareOut("unitA", qA.pop_front(), {aData, aA, aB, aC, aBusy, aDone});
   end

   always @(posedge clk) begin
      #1;
      if (qB.size() > 0)
         compareOut("unitB", qB.pop_front(), {bData, bA, bB, bC, bBusy, bDone});
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse iStart for one cycle with the given data; returns on the negedge
   // just after the capturing edge.
   task automatic startFrame(input logic [7:0] d);
      iData  = d;
      iStart = 1'b1;
      cyc(1);
      iStart = 1'b0;
   endtask

   initial begin
      cyc(3);
      rst = 1'b0;
      cyc(2);

      // Single frame
      startFrame(8'h0F);
      cyc(38);

      // Data hold while busy
      startFrame(8'hAA);
      cyc(10);
      iData = 8'h55;
      cyc(28);

      // Abort during select 011 of unitA, then a full frame
      startFrame(8'h12);
      cyc(13);
      iAbort = 1'b1;
      cyc(1);
      iAbort = 1'b0;
      cyc(3);
      startFrame(8'h3C);
      cyc(38);

      // Ignored mid-scan start, then iStart held through the DONE cycle
      startFrame(8'h81);
      cyc(6);
      iData  = 8'h7E;
      iStart = 1'b1;
      cyc(1);
      iStart = 1'b0;
      cyc(20);
      iData  = 8'hC3;
      iStart = 1'b1;
      cyc(10);
      iStart = 1'b0;
      cyc(30);

      // Abort in the same cycle as frame completion
      startFrame(8'h5A);
      cyc(31);
      iAbort = 1'b1;
      cyc(1);
      iAbort = 1'b0;
      cyc(4);

      // Reset mid-frame (unitA at select 101)
      startFrame(8'hE7);
      cyc(21);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(4);

      // Continuous data change before wrap
      startFrame(8'h0F);
      cyc(3);
      iData = 8'hAA;
      cyc(12);
      iAbort = 1'b1;
      cyc(1);
      iAbort = 1'b0;
      cyc(2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 399) == 0);
         iAbort = ($urandom_range(0, 49) == 0);
         iStart = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0)
            iData = 8'($urandom);
         cyc(1);
      end
      rst    = 1'b0;
      iAbort = 1'b0;
      iStart = 1'b0;
      cyc(3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
